// File: rtl/blink_period_monitor.sv
// Blink period monitor: synchronises an asynchronous blink waveform, measures
// the clock-cycle spacing of its rising edges, flags out-of-tolerance periods
// and raises a stuck flag when no rising edge arrives within a timeout.
module blink_period_monitor #(
    parameter int unsigned CNT_W      = 21,
    parameter int unsigned EXP_PERIOD = 20,
    parameter int unsigned TOL        = 2,
    parameter int unsigned TIMEOUT    = 100,
    parameter int unsigned EDGE_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              blink_in,
    output logic [CNT_W-1:0]  period,
    output logic              period_valid,
    output logic              mismatch,
    output logic              stuck,
    output logic [EDGE_W-1:0] edge_count
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] EXP_C     = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STUCK   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic              s1;
    logic              s2;
    logic              prev;
    logic              rise;

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  diff;
    logic              out_of_tol;
    logic              timeout_hit;

    logic [CNT_W-1:0]  period_next;
    logic              period_valid_next;
    logic              mismatch_next;
    logic              stuck_next;
    logic [EDGE_W-1:0] edge_count_next;

    // Two-flop synchroniser plus a delayed copy for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= blink_in;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign rise        = s2 & ~prev;
    assign diff        = (cnt >= EXP_C) ? (cnt - EXP_C) : (EXP_C - cnt);
    assign out_of_tol  = (diff > TOL_C);
    assign timeout_hit = (cnt == TIMEOUT_C);

    // Cycles since the last rising edge; restarts at 1 so N-cycle spacing reads N.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= CNT_ONE;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-output logic; a rise always beats a same-cycle timeout.
    always_comb begin
        state_next        = state;
        period_next       = period;
        period_valid_next = 1'b0;
        mismatch_next     = mismatch;
        stuck_next        = stuck;
        edge_count_next   = edge_count;

        case (state)
            IDLE: begin
                if (rise) begin
                    state_next      = MEASURE;
                    edge_count_next = edge_count + EDGE_W'(1);
                end else if (timeout_hit) begin
                    state_next = STUCK;
                    stuck_next = 1'b1;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_next       = cnt;
                    period_valid_next = 1'b1;
                    mismatch_next     = out_of_tol;
                    edge_count_next   = edge_count + EDGE_W'(1);
                end else if (timeout_hit) begin
                    state_next = STUCK;
                    stuck_next = 1'b1;
                end
            end
            STUCK: begin
                stuck_next = 1'b1;
                if (rise) begin
                    state_next      = MEASURE;
                    stuck_next      = 1'b0;
                    edge_count_next = edge_count + EDGE_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period       <= '0;
            period_valid <= 1'b0;
            mismatch     <= 1'b0;
            stuck        <= 1'b0;
            edge_count   <= '0;
        end else begin
            period       <= period_next;
            period_valid <= period_valid_next;
            mismatch     <= mismatch_next;
            stuck        <= stuck_next;
            edge_count   <= edge_count_next;
        end
    end

endmodule

// File: tb/tb_blink_period_monitor.sv
// Scoreboard bench for blink_period_monitor: stimulus pushes the expected
// period/mismatch/edge_count for each closing rise, a monitor pops on period_valid.
module tb_blink_period_monitor;

    localparam int unsigned CNT_W  = 21;
    localparam int unsigned EDGE_W = 4;

    typedef struct packed {
        logic [CNT_W-1:0]  period;
        logic              mm;
        logic [EDGE_W-1:0] edges;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              blink_in;
    logic [CNT_W-1:0]  period;
    logic              period_valid;
    logic              mismatch;
    logic              stuck;
    logic [EDGE_W-1:0] edge_count;

    exp_t              q[$];
    exp_t              mon_e;
    logic              pv_prev = 1'b0;
    logic [EDGE_W-1:0] model_edges;
    int                n_check = 0;
    int                n_pass  = 0;

    blink_period_monitor #(
        .CNT_W      (CNT_W),
        .EXP_PERIOD (20),
        .TOL        (2),
        .TIMEOUT    (100),
        .EDGE_W     (EDGE_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .blink_in     (blink_in),
        .period       (period),
        .period_valid (period_valid),
        .mismatch     (mismatch),
        .stuck        (stuck),
        .edge_count   (edge_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_check++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // One rise followed by hi cycles high and lo cycles low; optionally queue
    // the measurement this rise closes (per = spacing from the previous rise).
    task automatic blink(input int hi, input int lo, input bit push, input int per, input bit mm);
        exp_t e;
        blink_in    = 1'b1;
        model_edges = model_edges + EDGE_W'(1);
        if (push) begin
            e = '{period: CNT_W'(per), mm: mm, edges: model_edges};
            q.push_back(e);
        end
        repeat (hi) @(negedge clk);
        blink_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_period"},       32'(period),       32'd0);
        check({tag, "_period_valid"}, 32'(period_valid), 32'd0);
        check({tag, "_mismatch"},     32'(mismatch),     32'd0);
        check({tag, "_stuck"},        32'(stuck),        32'd0);
        check({tag, "_edge_count"},   32'(edge_count),   32'd0);
    endtask

    // Monitor: every period_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (period_valid) begin
            check("pv_not_back_to_back", 32'(pv_prev), 32'd0);
            if (q.size() == 0) begin
                n_check++;
                $display("FAIL unexpected_period_valid: got pulse with period=%0d, required no pulse", period);
            end else begin
                mon_e = q.pop_front();
                check("period",     32'(period),     32'(mon_e.period));
                check("mismatch",   32'(mismatch),   32'(mon_e.mm));
                check("edge_count", 32'(edge_count), 32'(mon_e.edges));
            end
        end
        pv_prev = period_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        blink_in    = 1'b0;
        model_edges = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        reset = 1'b0;

        // Test 1: 5 rises of period 20.
        blink(10, 10, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) blink(10, 10, 1'b1, 20, 1'b0);
        check("t1_edge_count", 32'(edge_count), 32'd5);

        // Test 2: periods 22 (in tolerance), 23 (out), 18 (in).
        blink(11, 11, 1'b1, 20, 1'b0);
        blink(12, 11, 1'b1, 22, 1'b0);
        blink(9, 9, 1'b1, 23, 1'b1);

        // Test 3: last rise, then hold low until stuck.
        blink_in    = 1'b1;
        model_edges = model_edges + EDGE_W'(1);
        q.push_back('{period: CNT_W'(18), mm: 1'b0, edges: model_edges});
        repeat (10) @(negedge clk);
        blink_in = 1'b0;
        repeat (92) @(negedge clk);
        check("t3_stuck_before_timeout", 32'(stuck), 32'd0);
        @(negedge clk);
        check("t3_stuck_at_timeout", 32'(stuck), 32'd1);
        check("t3_period_held", 32'(period), 32'd18);
        check("t3_mismatch_held", 32'(mismatch), 32'd0);
        repeat (20) @(negedge clk);
        check("t3_stuck_stays", 32'(stuck), 32'd1);
        blink(10, 10, 1'b0, 0, 1'b0);
        check("t3_stuck_cleared", 32'(stuck), 32'd0);
        blink(10, 10, 1'b1, 20, 1'b0);

        // Test 4: reset mid-period, then re-arm.
        blink(10, 5, 1'b1, 20, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_mid");
        reset       = 1'b0;
        model_edges = '0;
        blink(10, 10, 1'b0, 0, 1'b0);
        blink(10, 10, 1'b1, 20, 1'b0);

        // Test 5: toggle every clock, period 2.
        blink(1, 1, 1'b1, 20, 1'b0);
        for (int i = 0; i < 8; i++) blink(1, 1, 1'b1, 2, 1'b1);
        repeat (5) @(negedge clk);

        // Test 6: 17 rises after reset wrap the 4-bit edge counter to 1.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset       = 1'b0;
        model_edges = '0;
        blink(3, 3, 1'b0, 0, 1'b0);
        for (int i = 0; i < 16; i++) blink(3, 3, 1'b1, 6, 1'b1);
        check("t6_edge_wrap", 32'(edge_count), 32'd1);

        // Constant-high input also ends in stuck.
        blink_in    = 1'b1;
        model_edges = model_edges + EDGE_W'(1);
        q.push_back('{period: CNT_W'(6), mm: 1'b1, edges: model_edges});
        repeat (102) @(negedge clk);
        check("t7_high_stuck_before", 32'(stuck), 32'd0);
        @(negedge clk);
        check("t7_high_stuck", 32'(stuck), 32'd1);
        check("t7_edge_count", 32'(edge_count), 32'd2);

        repeat (10) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
